// File: rtl/calc_rr_scheduler.sv
// calc_rr_scheduler -- two requesters share one CombCalc/AddSub datapath.
//
// Round-robin arbitration picks one request at a time. The operands and the
// owner are latched. CombCalc evaluates the latched operands for one cycle,
// and the result register captures its output. The result is then held on
// the shared response bus until the owner takes it. Only one operation is
// in flight at any time, so an operation takes at least 3 cycles.
//
// Ports:
//   clk, rst_n             clock; synchronous active-low reset
//   reqX_valid/ready       request handshake for requester X (0 or 1)
//   reqX_op/a/b            opcode and signed operands for requester X
//   rspX_valid/ready       response handshake; the result belongs to X
//   rsp_r, rsp_ovf         shared result bus and its signed overflow flag
//   busy                   high whenever the FSM is not IDLE
//   ovf_cnt (optional)     saturating count of overflowed responses
//
// Build option: define CALC_OVF_COUNT_EN to add the ovf_cnt[7:0] output.

// CombCalc: AddSub with operand swap (op[2]) and absolute value (op[1]).
module calc_rr_comb #(
  parameter int W = 16
) (
  input  logic [2:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] r_o,
  output logic         ovf_o
);
  logic [W-1:0] x, y;

  always_comb begin
    x     = op_i[2] ? b_i : a_i;
    y     = op_i[2] ? a_i : b_i;
    r_o   = '0;
    ovf_o = 1'b0;
    if (op_i[1]) begin
      // |y| is computed as 0 - y. The only overflowing input is the most
      // negative value, and that result is again negative.
      if (y[W-1]) begin
        r_o   = '0 - y;
        ovf_o = r_o[W-1];
      end else begin
        r_o = y;
      end
    end else if (op_i[0]) begin
      r_o   = x - y;
      ovf_o = (x[W-1] != y[W-1]) && (r_o[W-1] != x[W-1]);
    end else begin
      r_o   = x + y;
      ovf_o = (x[W-1] == y[W-1]) && (r_o[W-1] != x[W-1]);
    end
  end
endmodule

module calc_rr_scheduler #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp_r,
  output logic         rsp_ovf,
`ifdef CALC_OVF_COUNT_EN
  output logic [7:0]   ovf_cnt,
`endif
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e       state_q, state_d;
  logic         owner_q, last_q;
  logic [2:0]   op_q;
  logic [W-1:0] a_q, b_q, r_q;
  logic         ovf_q;
  logic         grant, accept, rsp_hs;
  logic [W-1:0] calc_r;
  logic         calc_ovf;

  calc_rr_comb #(.W(W)) u_calc (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .r_o  (calc_r),
    .ovf_o(calc_ovf)
  );

  // A tie goes to the requester that did not win last time. Otherwise the
  // only valid requester wins. With no valid request the grant value does
  // not matter, because both readys are gated by the valids.
  assign grant      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready = (state_q == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign rsp0_valid = (state_q == RESP) && !owner_q;
  assign rsp1_valid = (state_q == RESP) && owner_q;
  assign rsp_hs     = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
  assign rsp_r      = r_q;
  assign rsp_ovf    = ovf_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= grant;
        last_q  <= grant;
        op_q    <= grant ? req1_op : req0_op;
        a_q     <= grant ? req1_a  : req0_a;
        b_q     <= grant ? req1_b  : req0_b;
      end
      if (state_q == EXEC) begin
        r_q   <= calc_r;
        ovf_q <= calc_ovf;
      end
    end
  end

`ifdef CALC_OVF_COUNT_EN
  logic [7:0] ovf_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n)
      ovf_cnt_q <= '0;
    else if (rsp_hs && ovf_q && ovf_cnt_q != 8'hFF)
      ovf_cnt_q <= ovf_cnt_q + 8'd1;
  end
  assign ovf_cnt = ovf_cnt_q;
`endif
endmodule
